pong_game_logic: RTL and testbench

//  Pong game-state engine; sits directly upstream of the frame renderer and drives its

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_game_logic_if.sv | 37 +++
 rtl/pong_paddle_ctrl.sv | 55 +++++
 rtl/pong_game_logic.sv | 232 +++++++++++++++++++++++
 tb/tb_pong_game_logic.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : screen geometry, start positions and FSM encoding for Pong
// Rev 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int WALL_TOP      = 2;
  localparam int WALL_BOT      = SCREEN_H - 2;
  localparam int PADDLE_L_FACE = 15;
  localparam int PADDLE_R_FACE = 620;

  localparam logic [9:0] PADDLE_START_Y = 10'd215;
  localparam logic [9:0] BALL_START_X   = 10'd315;
  localparam logic [9:0] BALL_START_Y   = 10'd235;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_e;

endpackage

`default_nettype wire

// File: rtl/pong_game_logic_if.sv
// ============================================================================
// pong_game_logic_if : frame tick/buttons in, game state out to the renderer
// Rev 1.0
// ============================================================================
`default_nettype none

interface pong_game_logic_if;

  logic       frame_tick;
  logic       btn_l_up;
  logic       btn_l_dn;
  logic       btn_r_up;
  logic       btn_r_dn;
  logic [9:0] paddle_left_pos;
  logic [9:0] paddle_right_pos;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       point_pulse;
  logic       game_over;

  modport master (
    input  frame_tick, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    output paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y,
           score_left, score_right, point_pulse, game_over
  );

  modport slave (
    output frame_tick, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    input  paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y,
           score_left, score_right, point_pulse, game_over
  );

endinterface

`default_nettype wire

// File: rtl/pong_paddle_ctrl.sv
// ============================================================================
// pong_paddle_ctrl : one paddle, stepped per frame and clamped to the walls
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_HEIGHT = 50,
  parameter int PADDLE_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_en,
  input  logic       recentre,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [9:0] pos
);

  localparam logic [10:0] POS_MIN = 11'(WALL_TOP);
  localparam logic [10:0] POS_MAX = 11'(WALL_BOT - PADDLE_HEIGHT);
  localparam logic [10:0] STEP    = 11'(PADDLE_STEP);

  logic [9:0]  pos_q;
  logic [9:0]  pos_d;
  logic [10:0] pos_ext;

  assign pos_ext = {1'b0, pos_q};

  // Clamp is decided before the subtraction so the top wall never wraps.
  always_comb begin
    pos_d = pos_q;
    if (recentre) begin
      pos_d = PADDLE_START_Y;
    end else if (move_en && btn_up && !btn_dn) begin
      if (pos_ext <= POS_MIN + STEP) pos_d = POS_MIN[9:0];
      else                           pos_d = pos_q - STEP[9:0];
    end else if (move_en && btn_dn && !btn_up) begin
      if (pos_ext + STEP >= POS_MAX) pos_d = POS_MAX[9:0];
      else                           pos_d = pos_q + STEP[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= PADDLE_START_Y;
    else        pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

`default_nettype wire

// File: rtl/pong_game_logic.sv
// ============================================================================
// pong_game_logic : per-frame Pong engine (FSM, ball, collisions, scores)
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_game_logic
  import pong_pkg::*;
#(
  parameter int PADDLE_HEIGHT = 50,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_SIZE     = 10,
  parameter int BALL_DX       = 2,
  parameter int BALL_DY       = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  pong_game_logic_if.master bus
);

  localparam int              CNT_W      = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 2);
  localparam logic [10:0] SZ          = 11'(BALL_SIZE);
  localparam logic [10:0] DX          = 11'(BALL_DX);
  localparam logic [10:0] DY          = 11'(BALL_DY);
  localparam logic [10:0] PH          = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] Y_TOP_STOP  = 11'(WALL_TOP);
  localparam logic [10:0] Y_TOP_HIT   = 11'(WALL_TOP + BALL_DY);
  localparam logic [10:0] Y_BOT_STOP  = 11'(WALL_BOT - BALL_SIZE);
  localparam logic [10:0] X_L_HIT_MAX = 11'(PADDLE_L_FACE + BALL_DX);
  localparam logic [10:0] X_L_STOP    = 11'(PADDLE_L_FACE + 1);
  localparam logic [10:0] X_R_FACE    = 11'(PADDLE_R_FACE);
  localparam logic [10:0] X_R_STOP    = 11'(PADDLE_R_FACE - BALL_SIZE);
  localparam logic [10:0] X_EDGE      = 11'(SCREEN_W);
  localparam logic [3:0]  WIN         = 4'(WIN_SCORE);

  pong_state_e      state_q, state_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_x_q, dir_x_d;         // 1 = moving right
  logic             dir_y_q, dir_y_d;         // 1 = moving down
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             point_pulse_q, point_pulse_d;
  logic             game_over_q, game_over_d;
  logic             scorer_r_q, scorer_r_d;

  logic [9:0]  pos_l, pos_r;
  logic        paddle_move, paddle_recentre;
  logic        any_btn;
  logic [10:0] bx, by, pl, pr;
  logic        hit_l, hit_r;

  pong_paddle_ctrl #(
    .PADDLE_HEIGHT (PADDLE_HEIGHT),
    .PADDLE_STEP   (PADDLE_STEP)
  ) u_paddle_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .move_en  (paddle_move),
    .recentre (paddle_recentre),
    .btn_up   (bus.btn_l_up),
    .btn_dn   (bus.btn_l_dn),
    .pos      (pos_l)
  );

  pong_paddle_ctrl #(
    .PADDLE_HEIGHT (PADDLE_HEIGHT),
    .PADDLE_STEP   (PADDLE_STEP)
  ) u_paddle_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .move_en  (paddle_move),
    .recentre (paddle_recentre),
    .btn_up   (bus.btn_r_up),
    .btn_dn   (bus.btn_r_dn),
    .pos      (pos_r)
  );

  assign any_btn = bus.btn_l_up | bus.btn_l_dn | bus.btn_r_up | bus.btn_r_dn;
  assign bx      = {1'b0, ball_x_q};
  assign by      = {1'b0, ball_y_q};
  // Paddle registers still hold the pre-tick positions here.
  assign pl      = {1'b0, pos_l};
  assign pr      = {1'b0, pos_r};
  assign hit_l   = (by + SZ > pl) && (by < pl + PH);
  assign hit_r   = (by + SZ > pr) && (by < pr + PH);

  always_comb begin
    state_d         = state_q;
    serve_cnt_d     = serve_cnt_q;
    ball_x_d        = ball_x_q;
    ball_y_d        = ball_y_q;
    dir_x_d         = dir_x_q;
    dir_y_d         = dir_y_q;
    score_l_d       = score_l_q;
    score_r_d       = score_r_q;
    scorer_r_d      = scorer_r_q;
    point_pulse_d   = 1'b0;
    paddle_move     = 1'b0;
    paddle_recentre = 1'b0;

    if (bus.frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          paddle_move = 1'b1;
          ball_x_d    = BALL_START_X;
          ball_y_d    = BALL_START_Y;
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end

        ST_PLAY: begin
          paddle_move = 1'b1;
          if (dir_y_q) begin
            if (by + DY >= Y_BOT_STOP) begin
              ball_y_d = Y_BOT_STOP[9:0];
              dir_y_d  = 1'b0;
            end else begin
              ball_y_d = ball_y_q + DY[9:0];
            end
          end else if (by <= Y_TOP_HIT) begin
            ball_y_d = Y_TOP_STOP[9:0];
            dir_y_d  = 1'b1;
          end else begin
            ball_y_d = ball_y_q - DY[9:0];
          end

          if (!dir_x_q) begin
            if (bx <= X_L_HIT_MAX && bx >= X_L_STOP && hit_l) begin
              ball_x_d = X_L_STOP[9:0];
              dir_x_d  = 1'b1;
            end else if (bx <= DX) begin
              scorer_r_d = 1'b1;
              state_d    = ST_POINT;
            end else begin
              ball_x_d = ball_x_q - DX[9:0];
            end
          end else begin
            if (bx + SZ + DX >= X_R_FACE && bx + SZ <= X_R_FACE && hit_r) begin
              ball_x_d = X_R_STOP[9:0];
              dir_x_d  = 1'b0;
            end else if (bx + SZ + DX >= X_EDGE) begin
              scorer_r_d = 1'b0;
              state_d    = ST_POINT;
            end else begin
              ball_x_d = ball_x_q + DX[9:0];
            end
          end
        end

        ST_POINT: begin
          point_pulse_d = 1'b1;
          ball_x_d      = BALL_START_X;
          ball_y_d      = BALL_START_Y;
          serve_cnt_d   = '0;
          dir_x_d       = ~scorer_r_q;    // serve toward the player who lost
          if (scorer_r_q) begin
            if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
            state_d = (score_r_d == WIN) ? ST_OVER : ST_SERVE;
          end else begin
            if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
            state_d = (score_l_d == WIN) ? ST_OVER : ST_SERVE;
          end
        end

        ST_OVER: begin
          ball_x_d = BALL_START_X;
          ball_y_d = BALL_START_Y;
          if (any_btn) begin
            score_l_d       = 4'd0;
            score_r_d       = 4'd0;
            paddle_recentre = 1'b1;
            serve_cnt_d     = '0;
            state_d         = ST_SERVE;
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end

    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SERVE;
      serve_cnt_q   <= '0;
      ball_x_q      <= BALL_START_X;
      ball_y_q      <= BALL_START_Y;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      point_pulse_q <= 1'b0;
      game_over_q   <= 1'b0;
      scorer_r_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_cnt_q   <= serve_cnt_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      point_pulse_q <= point_pulse_d;
      game_over_q   <= game_over_d;
      scorer_r_q    <= scorer_r_d;
    end
  end

  assign bus.paddle_left_pos  = pos_l;
  assign bus.paddle_right_pos = pos_r;
  assign bus.ball_pos_x       = ball_x_q;
  assign bus.ball_pos_y       = ball_y_q;
  assign bus.score_left       = score_l_q;
  assign bus.score_right      = score_r_q;
  assign bus.point_pulse      = point_pulse_q;
  assign bus.game_over        = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_logic.sv
// ============================================================================
// tb_pong_game_logic : randomized play against a frame-level Pong model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pong_game_logic;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_POINT = 2;
  localparam int M_OVER  = 3;

  typedef struct {
    int pl;
    int pr;
    int bx;
    int by;
    int sl;
    int sr;
    int pulse;
    int over;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pong_game_logic_if bus();

  pong_game_logic dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  // Model: positions in pixels, velocity as +1/-1 direction times speed.
  int m_mode, m_cnt, m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_sl, m_sr;
  bit m_right_scored;
  int n_over  = 0;
  int n_ticks = 0;

  task automatic cmp(input string tag, input string fld, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d at %0t", tag, fld, act, expv, $time);
    end
  endtask

  task automatic check_out(input exp_t e, input string tag);
    cmp(tag, "paddle_left_pos",  int'(bus.paddle_left_pos),  e.pl);
    cmp(tag, "paddle_right_pos", int'(bus.paddle_right_pos), e.pr);
    cmp(tag, "ball_pos_x",       int'(bus.ball_pos_x),       e.bx);
    cmp(tag, "ball_pos_y",       int'(bus.ball_pos_y),       e.by);
    cmp(tag, "score_left",       int'(bus.score_left),       e.sl);
    cmp(tag, "score_right",      int'(bus.score_right),      e.sr);
    cmp(tag, "point_pulse",      int'(bus.point_pulse),      e.pulse);
    cmp(tag, "game_over",        int'(bus.game_over),        e.over);
  endtask

  function automatic exp_t model_view(input int pulse);
    exp_t e;
    e.pl = m_pl;  e.pr = m_pr;  e.bx = m_bx;  e.by = m_by;
    e.sl = m_sl;  e.sr = m_sr;  e.pulse = pulse;
    e.over = (m_mode == M_OVER) ? 1 : 0;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_SERVE; m_cnt = 0; m_pl = 215; m_pr = 215;
    m_bx = 315; m_by = 235; m_vx = 1; m_vy = 1; m_sl = 0; m_sr = 0;
    m_right_scored = 1'b0;
  endtask

  function automatic int move_paddle(input int p, input bit up, input bit dn);
    int n;
    n = p;
    if (up && !dn) n = p - 4;
    if (dn && !up) n = p + 4;
    if (n < 2)   n = 2;
    if (n > 428) n = 428;
    return n;
  endfunction

  function automatic bit overlaps(input int y, input int p);
    return (y + 10 > p) && (y < p + 50);
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd,
                            output exp_t e);
    int opl, opr, oy, pulse;
    opl = m_pl; opr = m_pr; oy = m_by; pulse = 0;
    case (m_mode)
      M_SERVE, M_PLAY: begin
        m_pl = move_paddle(m_pl, lu, ld);
        m_pr = move_paddle(m_pr, ru, rd);
        if (m_mode == M_SERVE) begin
          m_cnt++;
          if (m_cnt == 59) begin m_mode = M_PLAY; m_cnt = 0; end
        end else begin
          if (m_vy < 0 && oy <= 4)         begin m_by = 2;   m_vy = 1;  end
          else if (m_vy > 0 && oy + 2 >= 468) begin m_by = 468; m_vy = -1; end
          else m_by = oy + 2 * m_vy;
          if (m_vx < 0) begin
            if (m_bx >= 16 && m_bx <= 17 && overlaps(oy, opl)) begin m_bx = 16; m_vx = 1; end
            else if (m_bx <= 2) begin m_right_scored = 1'b1; m_mode = M_POINT; end
            else m_bx -= 2;
          end else begin
            if (m_bx + 12 >= 620 && m_bx + 10 <= 620 && overlaps(oy, opr)) begin
              m_bx = 610; m_vx = -1;
            end else if (m_bx + 12 >= 640) begin
              m_right_scored = 1'b0; m_mode = M_POINT;
            end else m_bx += 2;
          end
        end
      end
      M_POINT: begin
        pulse = 1;
        if (m_right_scored) begin m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_vx = -1; end
        else                begin m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_vx = 1;  end
        m_bx = 315; m_by = 235; m_cnt = 0;
        if (m_sl == 9 || m_sr == 9) begin m_mode = M_OVER; n_over++; end
        else m_mode = M_SERVE;
      end
      default: begin
        if (lu || ld || ru || rd) begin
          m_sl = 0; m_sr = 0; m_pl = 215; m_pr = 215; m_cnt = 0; m_mode = M_SERVE;
        end
      end
    endcase
    e = model_view(pulse);
  endtask

  task automatic do_tick(input bit lu, input bit ld, input bit ru, input bit rd);
    exp_t e;
    @(negedge clk);
    bus.btn_l_up = lu; bus.btn_l_dn = ld; bus.btn_r_up = ru; bus.btn_r_dn = rd;
    bus.frame_tick = 1'b1;
    model_tick(lu, ld, ru, rd, e);
    exp_q.push_back(e);
    n_ticks++;
  endtask

  // Buttons wiggle between ticks; they must have no effect there.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.btn_l_up = 1'($urandom_range(1)); bus.btn_l_dn = 1'($urandom_range(1));
      bus.btn_r_up = 1'($urandom_range(1)); bus.btn_r_dn = 1'($urandom_range(1));
    end
  endtask

  task automatic pick_btn(input int track_pct, input int pos, output bit up, output bit dn);
    int centre, target;
    if (int'($urandom_range(99)) < track_pct) begin
      centre = pos + 25;
      target = m_by + 5;
      up = (target < centre - 3);
      dn = (target > centre + 3);
    end else begin
      up = 1'($urandom_range(1));
      dn = 1'($urandom_range(1));
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   tick, rs;
    forever begin
      @(posedge clk);
      tick = bus.frame_tick;
      rs   = rst_n;
      #2;
      if (!rs || !rst_n) continue;
      if (tick) begin
        if (exp_q.size() == 0) begin
          cmp("scoreboard", "queue_depth", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check_out(e, "tick");
          last_exp = e;
        end
      end else begin
        e = last_exp;
        e.pulse = 0;
        check_out(e, "hold");
      end
    end
  end

  initial begin : stimulus
    bit   lu, ld, ru, rd, did_reset;
    exp_t e;
    did_reset = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0; bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
    model_reset();
    last_exp = model_view(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Drive both paddles into their clamps, then hold with both buttons.
    for (int i = 0; i < 70; i++) begin do_tick(1, 0, 0, 1); idle(1); end
    for (int i = 0; i < 5;  i++) begin do_tick(1, 1, 1, 1); idle(1); end

    while (n_over < 2 && n_ticks < 20000) begin
      if (m_mode == M_OVER) begin
        if ($urandom_range(2) == 0) begin
          lu = 1'($urandom_range(1)); ld = 1'($urandom_range(1));
          ru = 1'($urandom_range(1)); rd = 1'($urandom_range(1));
        end else begin
          lu = 0; ld = 0; ru = 0; rd = 0;
        end
      end else begin
        pick_btn(85, m_pl, lu, ld);
        pick_btn(20, m_pr, ru, rd);
      end
      do_tick(lu, ld, ru, rd);
      idle(int'($urandom_range(1, 2)));

      if (!did_reset && n_ticks > 300 && m_mode == M_PLAY) begin
        did_reset = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        e = model_view(0);
        check_out(e, "async_reset");
        exp_q.delete();
        last_exp = e;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
      end
    end

    idle(4);
    cmp("scoreboard", "leftover_entries", exp_q.size(), 0);
    cmp("run", "games_completed", n_over, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
